// File: rtl/mem_lane_arbiter_pkg.sv
// Shared types and helpers for the three-lane memory arbiter: FSM state
// encoding, lane count, lane slice offsets and a lowest-set-bit picker.
package mem_lane_arbiter_pkg;

  localparam int LANES = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GATHER,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_WR_SER,
    ST_DONE
  } state_t;

  typedef logic [LANES-1:0] lane_mask_t;
  typedef logic [1:0]       lane_idx_t;

  // Bit offset of a lane's address field inside a packed address bus.
  function automatic int addr_of(input int lane, input int address_len);
    return lane * address_len;
  endfunction

  // Bit offset of a lane's data field inside a packed data bus.
  function automatic int data_of(input int lane, input int data_len);
    return lane * data_len;
  endfunction

  // Index of the lowest set bit; an empty mask yields lane 0.
  function automatic lane_idx_t lowest_set(input lane_mask_t mask);
    lane_idx_t idx;
    idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) idx = lane_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_lane_arbiter_lane_pack.sv
// Combinational lane packer: lanes in active_mask drive their own
// address/data, every other lane mirrors the selected source lane so the
// shared RAM sees a harmless duplicate access on idle lanes.
module mem_lane_arbiter_lane_pack
  import mem_lane_arbiter_pkg::*;
#(
  parameter int DATA_LEN    = 16,
  parameter int ADDRESS_LEN = 8
) (
  input  logic [LANES-1:0]             active_mask,
  input  logic [1:0]                   src_lane,
  input  logic [LANES*ADDRESS_LEN-1:0] lane_addr,
  input  logic [LANES*DATA_LEN-1:0]    lane_data,
  output logic [LANES*ADDRESS_LEN-1:0] pack_addr,
  output logic [LANES*DATA_LEN-1:0]    pack_data
);

  logic [ADDRESS_LEN-1:0] src_addr;
  logic [DATA_LEN-1:0]    src_data;

  // Pick out the source lane's address and data for mirroring.
  always_comb begin
    src_addr = '0;
    src_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (src_lane == lane_idx_t'(i)) begin
        src_addr = lane_addr[addr_of(i, ADDRESS_LEN) +: ADDRESS_LEN];
        src_data = lane_data[data_of(i, DATA_LEN) +: DATA_LEN];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign pack_addr[addr_of(gi, ADDRESS_LEN) +: ADDRESS_LEN] =
        active_mask[gi] ? lane_addr[addr_of(gi, ADDRESS_LEN) +: ADDRESS_LEN] : src_addr;
      assign pack_data[data_of(gi, DATA_LEN) +: DATA_LEN] =
        active_mask[gi] ? lane_data[data_of(gi, DATA_LEN) +: DATA_LEN] : src_data;
    end
  endgenerate

endmodule

// File: rtl/mem_lane_arbiter.sv
// Barrier arbiter in front of the three-lane shared RAM. Gathers one request
// per enabled core, issues a single read cycle for all readers, then one
// parallel write cycle (or one cycle per writer when addresses collide),
// and finishes the batch with a one-cycle resp_valid pulse.
module mem_lane_arbiter
  import mem_lane_arbiter_pkg::*;
#(
  parameter int DATA_LEN    = 16,
  parameter int ADDRESS_LEN = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANES-1:0]             core_en,
  input  logic [LANES-1:0]             req_rd,
  input  logic [LANES-1:0]             req_wr,
  input  logic [LANES*ADDRESS_LEN-1:0] req_addr,
  input  logic [LANES*DATA_LEN-1:0]    req_data,
  output logic [LANES*DATA_LEN-1:0]    resp_data,
  output logic                         resp_valid,
  output logic                         busy,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [LANES*ADDRESS_LEN-1:0] mem_address,
  output logic [LANES*DATA_LEN-1:0]    mem_data_in,
  input  logic [LANES*DATA_LEN-1:0]    mem_data_out
);

  localparam int AW = LANES * ADDRESS_LEN;
  localparam int DW = LANES * DATA_LEN;

  state_t        state_reg;
  lane_mask_t    pending_reg;
  lane_mask_t    is_rd_reg;
  lane_mask_t    ser_mask_reg;
  logic [AW-1:0] lat_addr_reg;
  logic [DW-1:0] lat_data_reg;
  logic [DW-1:0] resp_data_reg;
  logic          resp_valid_reg;
  logic          busy_reg;
  logic          mem_read_reg;
  logic          mem_write_reg;
  logic [AW-1:0] mem_address_reg;
  logic [DW-1:0] mem_data_in_reg;

  logic          gather_window;
  lane_mask_t    take_lane;
  lane_mask_t    pending_next;
  lane_mask_t    is_rd_next;
  lane_mask_t    rd_mask;
  lane_mask_t    wr_mask;
  lane_mask_t    wr_rest;
  lane_mask_t    ser_rest;
  lane_mask_t    pack_mask;
  lane_idx_t     rd_first;
  lane_idx_t     wr_first;
  lane_idx_t     ser_first;
  lane_idx_t     pack_src;
  logic          collision;
  logic [AW-1:0] lat_addr_next;
  logic [DW-1:0] lat_data_next;
  logic [AW-1:0] pack_addr;
  logic [DW-1:0] pack_data;
  logic [DW-1:0] rd_capture;

  // Requests are only accepted while gathering; once a batch launches the
  // latched copy is frozen and core_en changes are ignored.
  assign gather_window = (state_reg == ST_IDLE) || (state_reg == ST_GATHER);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_latch
      assign take_lane[gi]    = gather_window && core_en[gi] && !pending_reg[gi] &&
                                (req_rd[gi] || req_wr[gi]);
      assign pending_next[gi] = gather_window ? (core_en[gi] && (pending_reg[gi] || take_lane[gi]))
                                              : pending_reg[gi];
      // rd wins over wr when both are raised on one lane.
      assign is_rd_next[gi]   = take_lane[gi] ? req_rd[gi] : is_rd_reg[gi];
      assign lat_addr_next[addr_of(gi, ADDRESS_LEN) +: ADDRESS_LEN] =
        take_lane[gi] ? req_addr[addr_of(gi, ADDRESS_LEN) +: ADDRESS_LEN]
                      : lat_addr_reg[addr_of(gi, ADDRESS_LEN) +: ADDRESS_LEN];
      assign lat_data_next[data_of(gi, DATA_LEN) +: DATA_LEN] =
        take_lane[gi] ? req_data[data_of(gi, DATA_LEN) +: DATA_LEN]
                      : lat_data_reg[data_of(gi, DATA_LEN) +: DATA_LEN];
      // Read data is kept only for lanes that actually read.
      assign rd_capture[data_of(gi, DATA_LEN) +: DATA_LEN] =
        rd_mask[gi] ? mem_data_out[data_of(gi, DATA_LEN) +: DATA_LEN] : '0;
    end
  endgenerate

  // The _next view already includes a request arriving on the launch edge,
  // so the final lane to join the barrier can launch in the same cycle.
  assign rd_mask   = pending_next & is_rd_next;
  assign wr_mask   = pending_next & ~is_rd_next;
  assign rd_first  = lowest_set(rd_mask);
  assign wr_first  = lowest_set(wr_mask);
  assign ser_first = lowest_set(ser_mask_reg);
  assign wr_rest   = wr_mask & ~(lane_mask_t'(1) << wr_first);
  assign ser_rest  = ser_mask_reg & ~(lane_mask_t'(1) << ser_first);

  // Two writers targeting the same address force lane-by-lane writes.
  always_comb begin
    collision = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (wr_mask[i] && wr_mask[j] &&
            (lat_addr_next[addr_of(i, ADDRESS_LEN) +: ADDRESS_LEN] ==
             lat_addr_next[addr_of(j, ADDRESS_LEN) +: ADDRESS_LEN])) begin
          collision = 1'b1;
        end
      end
    end
  end

  // Choose the packing for the access that the next edge will launch.
  always_comb begin
    pack_mask = rd_mask;
    pack_src  = rd_first;
    case (state_reg)
      ST_IDLE, ST_GATHER: begin
        if (!(|rd_mask)) begin
          pack_mask = collision ? '0 : wr_mask;
          pack_src  = wr_first;
        end
      end
      ST_RD_WAIT: begin
        pack_mask = collision ? '0 : wr_mask;
        pack_src  = wr_first;
      end
      ST_WR_SER: begin
        pack_mask = '0;
        pack_src  = ser_first;
      end
      default: ;
    endcase
  end

  mem_lane_arbiter_lane_pack #(
    .DATA_LEN    (DATA_LEN),
    .ADDRESS_LEN (ADDRESS_LEN)
  ) u_lane_pack (
    .active_mask (pack_mask),
    .src_lane    (pack_src),
    .lane_addr   (lat_addr_next),
    .lane_data   (lat_data_next),
    .pack_addr   (pack_addr),
    .pack_data   (pack_data)
  );

  // Batch sequencer; all RAM strobes and responses are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      pending_reg     <= '0;
      is_rd_reg       <= '0;
      ser_mask_reg    <= '0;
      lat_addr_reg    <= '0;
      lat_data_reg    <= '0;
      resp_data_reg   <= '0;
      resp_valid_reg  <= 1'b0;
      busy_reg        <= 1'b0;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
      mem_address_reg <= '0;
      mem_data_in_reg <= '0;
    end else begin
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      resp_valid_reg <= 1'b0;
      pending_reg    <= pending_next;
      is_rd_reg      <= is_rd_next;
      lat_addr_reg   <= lat_addr_next;
      lat_data_reg   <= lat_data_next;
      case (state_reg)
        ST_IDLE: begin
          if (|pending_next) state_reg <= ST_GATHER;
        end
        ST_GATHER: begin
          if (pending_next == '0) begin
            state_reg <= ST_IDLE;
          end else if (pending_next == core_en) begin
            busy_reg        <= 1'b1;
            resp_data_reg   <= '0;
            mem_address_reg <= pack_addr;
            mem_data_in_reg <= pack_data;
            if (|rd_mask) begin
              mem_read_reg <= 1'b1;
              state_reg    <= ST_RD;
            end else begin
              mem_write_reg <= 1'b1;
              ser_mask_reg  <= wr_rest;
              state_reg     <= collision ? ST_WR_SER : ST_WR;
            end
          end
        end
        ST_RD: begin
          state_reg <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          resp_data_reg <= rd_capture;
          if (|wr_mask) begin
            mem_write_reg   <= 1'b1;
            mem_address_reg <= pack_addr;
            mem_data_in_reg <= pack_data;
            ser_mask_reg    <= wr_rest;
            state_reg       <= collision ? ST_WR_SER : ST_WR;
          end else begin
            resp_valid_reg <= 1'b1;
            state_reg      <= ST_DONE;
          end
        end
        ST_WR: begin
          resp_valid_reg <= 1'b1;
          state_reg      <= ST_DONE;
        end
        ST_WR_SER: begin
          if (ser_mask_reg == '0) begin
            resp_valid_reg <= 1'b1;
            state_reg      <= ST_DONE;
          end else begin
            mem_write_reg   <= 1'b1;
            mem_address_reg <= pack_addr;
            mem_data_in_reg <= pack_data;
            ser_mask_reg    <= ser_rest;
          end
        end
        ST_DONE: begin
          pending_reg <= '0;
          busy_reg    <= 1'b0;
          state_reg   <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign resp_data   = resp_data_reg;
  assign resp_valid  = resp_valid_reg;
  assign busy        = busy_reg;
  assign mem_read    = mem_read_reg;
  assign mem_write   = mem_write_reg;
  assign mem_address = mem_address_reg;
  assign mem_data_in = mem_data_in_reg;

endmodule

// File: tb/tb_mem_lane_arbiter.sv
// Bench for mem_lane_arbiter: directed batches with hand-computed results,
// a behavioural three-lane RAM, and a scoreboard monitor that checks each
// resp_valid pulse against the queued expectation.
module tb_mem_lane_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  core_en = '0;
  logic [2:0]  req_rd = '0;
  logic [2:0]  req_wr = '0;
  logic [23:0] req_addr = '0;
  logic [47:0] req_data = '0;
  logic [47:0] resp_data;
  logic        resp_valid;
  logic        busy;
  logic        mem_read;
  logic        mem_write;
  logic [23:0] mem_address;
  logic [47:0] mem_data_in;
  logic [47:0] mem_data_out;

  logic        ram_init = 1'b1;
  logic [15:0] ram  [0:255];
  logic [15:0] snap [0:255];

  int vectors = 0;
  int miscompares = 0;
  int strobe_total = 0;

  typedef struct {
    string       name;
    logic [47:0] data;
    int          n_rd;
    int          n_wr;
    int          lat;
    logic [23:0] rd_addr;
  } exp_t;

  exp_t exp_q[$];

  mem_lane_arbiter #(.DATA_LEN(16), .ADDRESS_LEN(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_en      (core_en),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .resp_data    (resp_data),
    .resp_valid   (resp_valid),
    .busy         (busy),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input int a);
    case (a)
      'h40: return 16'd23;
      'h41: return 16'd45;
      'h42: return 16'd44;
      'h3E: return 16'd4;
      'h3F: return 16'd4;
      default: return 16'd0;
    endcase
  endfunction

  // Three-lane RAM: synchronous read, all lanes written on mem_write.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int a = 0; a < 256; a++) ram[a] <= init_word(a);
      mem_data_out <= '0;
    end else begin
      if (mem_write)
        for (int l = 0; l < 3; l++) ram[mem_address[l*8 +: 8]] <= mem_data_in[l*16 +: 16];
      if (mem_read)
        for (int l = 0; l < 3; l++) mem_data_out[l*16 +: 16] <= ram[mem_address[l*8 +: 8]];
    end
  end

  function automatic logic [23:0] a3(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2);
    return {l2, l1, l0};
  endfunction

  function automatic logic [47:0] d3(input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] l2);
    return {l2, l1, l0};
  endfunction

  task automatic check(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", tag, what, act, exp);
    end
  endtask

  task automatic expect_resp(input string name, input logic [47:0] data, input int n_rd,
                             input int n_wr, input int lat, input logic [23:0] rd_addr);
    exp_t e;
    e.name = name; e.data = data; e.n_rd = n_rd; e.n_wr = n_wr; e.lat = lat; e.rd_addr = rd_addr;
    exp_q.push_back(e);
  endtask

  task automatic wait_resp(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!resp_valid && k < 40);
    check(name, "resp_seen", 64'(resp_valid), 64'(1));
  endtask

  task automatic run_batch(input string name, input logic [2:0] en, input logic [2:0] rd,
                           input logic [2:0] wr, input logic [23:0] addr, input logic [47:0] data);
    @(posedge clk);
    #1;
    core_en = en; req_rd = rd; req_wr = wr; req_addr = addr; req_data = data;
    wait_resp(name);
    req_rd = '0; req_wr = '0;
    $display("batch %s: resp_data=0x%012h", name, resp_data);
  endtask

  // Scoreboard monitor: counts strobe cycles and compares each response.
  initial begin
    int cyc, first_strobe, n_rd_seen, n_wr_seen;
    logic [23:0] rd_addr_seen;
    exp_t e;
    cyc = 0; first_strobe = -1; n_rd_seen = 0; n_wr_seen = 0; rd_addr_seen = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        first_strobe = -1; n_rd_seen = 0; n_wr_seen = 0;
      end else begin
        if (mem_read || mem_write) begin
          check("strobe", "rd_wr_exclusive", 64'(mem_read & mem_write), 64'(0));
          if (first_strobe < 0) first_strobe = cyc;
          strobe_total++;
        end
        if (mem_read) begin
          n_rd_seen++;
          rd_addr_seen = mem_address;
        end
        if (mem_write) n_wr_seen++;
        if (resp_valid) begin
          check("monitor", "resp_expected", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, "resp_data", 64'(resp_data), 64'(e.data));
            check(e.name, "busy_at_resp", 64'(busy), 64'(1));
            check(e.name, "read_cycles", 64'(n_rd_seen), 64'(e.n_rd));
            check(e.name, "write_cycles", 64'(n_wr_seen), 64'(e.n_wr));
            check(e.name, "latency", 64'(cyc - first_strobe), 64'(e.lat));
            if (e.n_rd > 0) check(e.name, "read_address", 64'(rd_addr_seen), 64'(e.rd_addr));
          end
          first_strobe = -1; n_rd_seen = 0; n_wr_seen = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, base, diffs;
    repeat (3) @(negedge clk);
    check("reset", "resp_valid", 64'(resp_valid), 64'(0));
    check("reset", "busy", 64'(busy), 64'(0));
    check("reset", "mem_read", 64'(mem_read), 64'(0));
    check("reset", "mem_write", 64'(mem_write), 64'(0));
    check("reset", "mem_address", 64'(mem_address), 64'(0));
    check("reset", "mem_data_in", 64'(mem_data_in), 64'(0));
    check("reset", "resp_data", 64'(resp_data), 64'(0));
    ram_init = 1'b0;
    rst = 1'b0;

    expect_resp("full_rd", d3(23, 45, 44), 1, 0, 2, a3(8'h40, 8'h41, 8'h42));
    run_batch("full_rd", 3'b111, 3'b111, 3'b000, a3(8'h40, 8'h41, 8'h42), '0);

    expect_resp("part_rd", d3(4, 4, 0), 1, 0, 2, a3(8'h3E, 8'h3F, 8'h3E));
    run_batch("part_rd", 3'b011, 3'b111, 3'b000, a3(8'h3E, 8'h3F, 8'h55), '0);

    expect_resp("par_wr", '0, 0, 1, 1, '0);
    run_batch("par_wr", 3'b111, 3'b000, 3'b111, a3(8'h60, 8'h61, 8'h62), d3(7, 8, 9));

    expect_resp("par_wr_rb", d3(7, 8, 9), 1, 0, 2, a3(8'h60, 8'h61, 8'h62));
    run_batch("par_wr_rb", 3'b111, 3'b111, 3'b000, a3(8'h60, 8'h61, 8'h62), '0);

    expect_resp("coll_wr", '0, 0, 3, 3, '0);
    run_batch("coll_wr", 3'b111, 3'b000, 3'b111, a3(8'h60, 8'h61, 8'h60), d3(5, 3, 6));

    expect_resp("coll_rb", d3(6, 3, 6), 1, 0, 2, a3(8'h60, 8'h61, 8'h60));
    run_batch("coll_rb", 3'b111, 3'b111, 3'b000, a3(8'h60, 8'h61, 8'h60), '0);

    expect_resp("mixed", d3(23, 0, 0), 1, 1, 3, a3(8'h40, 8'h40, 8'h40));
    run_batch("mixed", 3'b111, 3'b001, 3'b111, a3(8'h40, 8'h50, 8'h51), d3(16'hFFFF, 16'h1234, 16'hBEEF));

    expect_resp("mixed_rb", d3(16'h1234, 16'hBEEF, 23), 1, 0, 2, a3(8'h50, 8'h51, 8'h40));
    run_batch("mixed_rb", 3'b111, 3'b111, 3'b000, a3(8'h50, 8'h51, 8'h40), '0);

    // Staggered arrivals: nothing may launch until the last lane joins.
    @(posedge clk);
    #1;
    expect_resp("stagger", d3(45, 23, 44), 1, 0, 2, a3(8'h41, 8'h40, 8'h42));
    base = strobe_total;
    core_en = 3'b111; req_addr = a3(8'h41, 8'h40, 8'h42); req_rd = 3'b001;
    repeat (3) @(posedge clk);
    #1;
    req_rd = 3'b101;
    repeat (2) @(posedge clk);
    #1;
    check("stagger", "no_early_strobe", 64'(strobe_total - base), 64'(0));
    check("stagger", "not_busy_early", 64'(busy), 64'(0));
    req_rd = 3'b111;
    wait_resp("stagger");
    req_rd = '0;
    $display("batch stagger: resp_data=0x%012h", resp_data);

    for (int a = 0; a < 256; a++) snap[a] = ram[a];
    expect_resp("part_wr", '0, 0, 1, 1, '0);
    run_batch("part_wr", 3'b010, 3'b000, 3'b010, a3(8'h11, 8'h70, 8'h22), d3(16'hDEAD, 1, 16'hCAFE));
    @(negedge clk);
    diffs = 0;
    for (int a = 0; a < 256; a++) if (a != 'h70 && ram[a] !== snap[a]) diffs++;
    check("part_wr", "other_addresses_unchanged", 64'(diffs), 64'(0));

    expect_resp("part_wr_rb", d3(0, 1, 0), 1, 0, 2, a3(8'h70, 8'h70, 8'h70));
    run_batch("part_wr_rb", 3'b010, 3'b010, 3'b000, a3(8'h00, 8'h70, 8'h00), '0);

    // Reset while the read result is in flight.
    @(posedge clk);
    #1;
    core_en = 3'b001; req_rd = 3'b001; req_addr = a3(8'h40, 8'h00, 8'h00);
    req_data = d3(16'hAAAA, 16'h5555, 16'h0F0F);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!mem_read && k < 20);
    check("rst_mid", "read_launched", 64'(mem_read), 64'(1));
    @(posedge clk);
    #2;
    check("rst_mid", "busy_before_reset", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    check("rst_mid", "resp_valid", 64'(resp_valid), 64'(0));
    check("rst_mid", "busy", 64'(busy), 64'(0));
    check("rst_mid", "mem_read", 64'(mem_read), 64'(0));
    check("rst_mid", "mem_write", 64'(mem_write), 64'(0));
    check("rst_mid", "mem_address", 64'(mem_address), 64'(0));
    check("rst_mid", "mem_data_in", 64'(mem_data_in), 64'(0));
    check("rst_mid", "resp_data", 64'(resp_data), 64'(0));
    req_rd = '0; core_en = '0; req_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid", "no_resp_after_release", 64'(resp_valid), 64'(0));

    expect_resp("post_rst_rd", d3(23, 0, 0), 1, 0, 2, a3(8'h40, 8'h40, 8'h40));
    run_batch("post_rst_rd", 3'b001, 3'b001, 3'b000, a3(8'h40, 8'h00, 8'h00), '0);

    repeat (5) @(negedge clk);
    check("end", "queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_lane_arbiter.md
Name: mem_lane_arbiter

Overview:
- Upstream neighbour of the 3-lane shared RAM (3 packed addresses, one shared read strobe, one shared write strobe, synchronous one-cycle read).
- Collects independent per-core read/write requests from the three processor cores and waits until every enabled core has a request pending (a barrier).
- Packs the requests onto the RAM's lane buses and returns per-lane read data with a one-cycle completion pulse.
- Makes partial-lane operation safe: the RAM always writes all three lanes, so idle lanes must be neutralised. Same-address write collisions are serialised.

Parameters:
DATA_LEN, 16, width of one memory word / one lane of data
ADDRESS_LEN, 8, width of one lane address
LANES, 3, number of cores/lanes (fixed to 3; no other value supported)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
core_en  input  LANES  per-lane enable; sampled only in IDLE/GATHER
req_rd  input  LANES  per-lane read request; held by core until resp_valid
req_wr  input  LANES  per-lane write request; held by core until resp_valid
req_addr  input  LANES*ADDRESS_LEN  packed lane addresses, lane0 in LSBs
req_data  input  LANES*DATA_LEN  packed write data, lane0 in LSBs
resp_data  output  LANES*DATA_LEN  packed read data; lane zero if lane did not read
resp_valid  output  1  one-cycle completion pulse for the whole batch
busy  output  1  high from batch launch until resp_valid cycle inclusive
mem_read  output  1  to RAM read
mem_write  output  1  to RAM write
mem_address  output  LANES*ADDRESS_LEN  to RAM address
mem_data_in  output  LANES*DATA_LEN  to RAM data_in
mem_data_out  input  LANES*DATA_LEN  from RAM data_out

Behaviour:
- Reset (async, immediate):
  - Outputs: all zero (resp_valid=0, busy=0, mem_read=0, mem_write=0, mem_address=0, mem_data_in=0, resp_data=0).
  - Internal: pending flags cleared; state=IDLE.
  - Reset mid-batch: the batch is abandoned; nothing further is written.
- Request latch and conflicts:
  - Per-lane pending flag set at the edge where (req_rd|req_wr) is high and the lane is enabled; address/data/type latched with it.
  - A lane with both rd and wr high is a read.
  - Requests on disabled lanes are ignored.
- States: IDLE, GATHER, RD, RD_WAIT, WR, WR_SER, DONE.
- IDLE:
  - core_en==0 → stay.
  - Any enabled request → GATHER.
- GATHER:
  - When pending == core_en (edge E0) → RD if any read is pending, else WR.
  - Outputs are registered, so mem_read/mem_write assert from E0.
- RD:
  - mem_read=1 for exactly one cycle.
  - Reading lanes drive their own address.
  - Non-reading lanes mirror the address of the lowest-index reading lane.
  - → RD_WAIT.
- RD_WAIT: capture mem_data_out into resp_data for reading lanes only; other lanes are zeroed.
- Write collision check: if no writes are pending, RD_WAIT → DONE. Otherwise collision = any two writing lanes have equal addresses.
  - No collision → WR.
  - Collision → WR_SER.
- WR (one cycle, mem_write=1):
  - Writing lanes drive their own address/data.
  - Non-writing lanes mirror the address and data of the lowest-index writing lane, so the RAM writes an identical value.
- WR_SER:
  - One cycle per writing lane, ascending lane index.
  - In each cycle all three lanes carry that single lane's address/data.
  - Net effect on a collision: the highest-index lane's data wins.
- DONE: resp_valid=1 for one cycle; pending cleared; busy drops next cycle → IDLE.
- Latency from E0 to resp_valid:
  - Read-only batch: 2 cycles.
  - Parallel write-only batch: 1 cycle.
  - Serial writes: n cycles, where n = number of writing lanes.
  - Mixed batch: 2 + (1 or n) cycles.
- Strobes: mem_read and mem_write are never high together. Both are low outside RD/WR/WR_SER.
- Changes to core_en while busy are ignored until IDLE.
- The core must keep its request high until resp_valid. A request still high in the cycle after DONE starts a new batch.

Decomposition:
- Shared package:
  - State enum.
  - LANES constant.
  - Lane slice helpers (addr_of(lane), data_of(lane)).
  - Lowest-set-bit function.
- Sub-module lane_pack: combinational packer. Given an active-lane mask and a selected source lane, it produces mem_address/mem_data_in with mirroring. It is reused by RD, WR and WR_SER.

Test Plan:
- Full read: en=111; lanes read 0x40,0x41,0x42 (preloaded 23,45,44) → one mem_read cycle; resp_data={44,45,23} at E0+2; resp_valid one cycle.
- Partial read: en=011; read 0x3E,0x3F (4,4) → mem_address lane2=0x3E; resp_data lane0=4, lane1=4, lane2=0.
- Parallel write: en=111; write 0x60←7, 0x61←8, 0x62←9 → single mem_write cycle; resp_valid at E0+1; readback returns 7,8,9.
- Collision: lane0 0x60←5, lane1 0x61←3, lane2 0x60←6 → three mem_write cycles (lanes 0,1,2); resp_valid at E0+3; mem[0x60]=6, mem[0x61]=3.
- Barrier/stagger: lane0 requests cycle 0, lane2 cycle 3, lane1 cycle 5 → no strobe before E0 (the cycle-5 edge); lane-1 partial write (en=010, 0x70←1) leaves every other address unchanged.
- Reset in RD_WAIT → outputs zero immediately; no resp_valid; after release, a fresh read of 0x40 returns 23 normally.
